// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared definitions for the instruction-decode front stage:
//   - EXT_CTRL_* extender control codes (shared with the immediate extender)
//   - RV32 base opcode constants
//   - IF/ID buffer occupancy encoding and the buffered entry type
//   - is_legal_opcode(): opcode legality helper
//     (only called when ID_ILLEGAL_DET_EN is defined)
// -----------------------------------------------------------------------------
package id_pkg;

    // Extender control codes
    localparam logic [5:0] EXT_CTRL_SHAMT = 6'b000000;
    localparam logic [5:0] EXT_CTRL_ITYPE = 6'b000001;
    localparam logic [5:0] EXT_CTRL_STYPE = 6'b000010;
    localparam logic [5:0] EXT_CTRL_BTYPE = 6'b000011;
    localparam logic [5:0] EXT_CTRL_UTYPE = 6'b000100;
    localparam logic [5:0] EXT_CTRL_JTYPE = 6'b000101;
    localparam logic [5:0] EXT_CTRL_NONE  = 6'b111111;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // funct3 values that turn OP-IMM into a shift-by-immediate
    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

    // IF/ID buffer occupancy
    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_TWO   = 2'd2
    } cnt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // A full 7-bit match also enforces instr[1:0] == 2'b11, since every
    // legal opcode ends in 11.
    function automatic logic is_legal_opcode(input logic [6:0] opc);
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_MISC_MEM,
            OPC_SYSTEM: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_if.sv
// -----------------------------------------------------------------------------
// id_if
// Handshake and data bundle of the decode front stage.
//   Upstream (fetch -> stage) : in_valid, in_ready, in_pc, in_instr
//   Downstream (stage -> ext) : out_valid, out_ready, out_pc, out_instr,
//                               register indices, raw immediate fields, out_EXTOp
//   out_illegal exists only when ID_ILLEGAL_DET_EN is defined.
// Modports:
//   slave  - the id_stage side
//   master - the environment side (fetch producer + downstream consumer)
// -----------------------------------------------------------------------------
interface id_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [4:0]  out_iimm_shamt;
    logic [11:0] out_iimm;
    logic [11:0] out_simm;
    logic [11:0] out_bimm;
    logic [19:0] out_uimm;
    logic [19:0] out_jimm;
    logic [5:0]  out_EXTOp;
`ifdef ID_ILLEGAL_DET_EN
    logic        out_illegal;
`endif

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr,
        output out_rs1, out_rs2, out_rd, out_iimm_shamt,
        output out_iimm, out_simm, out_bimm, out_uimm, out_jimm, out_EXTOp
`ifdef ID_ILLEGAL_DET_EN
        , output out_illegal
`endif
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr,
        input  out_rs1, out_rs2, out_rd, out_iimm_shamt,
        input  out_iimm, out_simm, out_bimm, out_uimm, out_jimm, out_EXTOp
`ifdef ID_ILLEGAL_DET_EN
        , input out_illegal
`endif
    );

endinterface

// File: rtl/id_decode.sv
// -----------------------------------------------------------------------------
// id_decode
// Purely combinational slicer/decoder for one RV32 instruction.
// Ports:
//   instr      in  32  instruction word
//   rs1/rs2/rd out 5   register indices
//   iimm_shamt out 5   shift amount field instr[24:20]
//   iimm/simm/bimm out 12, uimm/jimm out 20  raw (unextended) immediates
//   ext_op     out 6   extender control (EXT_CTRL_*)
//   illegal    out 1   opcode outside the legal set (ID_ILLEGAL_DET_EN only)
// -----------------------------------------------------------------------------
module id_decode
    import id_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [4:0]  iimm_shamt,
    output logic [11:0] iimm,
    output logic [11:0] simm,
    output logic [11:0] bimm,
    output logic [19:0] uimm,
    output logic [19:0] jimm,
    output logic [5:0]  ext_op
`ifdef ID_ILLEGAL_DET_EN
    , output logic      illegal
`endif
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];

    assign rs1        = instr[19:15];
    assign rs2        = instr[24:20];
    assign rd         = instr[11:7];
    assign iimm_shamt = instr[24:20];
    assign iimm       = instr[31:20];
    assign simm       = {instr[31:25], instr[11:7]};
    assign bimm       = {instr[31], instr[7], instr[30:25], instr[11:8]};
    assign uimm       = instr[31:12];
    assign jimm       = {instr[31], instr[19:12], instr[20], instr[30:21]};

    always_comb begin
        // NOTE: default assignment first so every path drives ext_op; no latch.
        ext_op = EXT_CTRL_NONE;
        case (w_opcode)
            OPC_OP_IMM: begin
                if (w_funct3 == F3_SLLI || w_funct3 == F3_SRXI) begin
                    ext_op = EXT_CTRL_SHAMT;
                end else begin
                    ext_op = EXT_CTRL_ITYPE;
                end
            end
            OPC_LOAD, OPC_JALR:  ext_op = EXT_CTRL_ITYPE;
            OPC_STORE:           ext_op = EXT_CTRL_STYPE;
            OPC_BRANCH:          ext_op = EXT_CTRL_BTYPE;
            OPC_LUI, OPC_AUIPC:  ext_op = EXT_CTRL_UTYPE;
            OPC_JAL:             ext_op = EXT_CTRL_JTYPE;
            default:             ext_op = EXT_CTRL_NONE;
        endcase
    end

`ifdef ID_ILLEGAL_DET_EN
    assign illegal = ~is_legal_opcode(w_opcode);
`endif

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// Instruction-decode front stage: 2-entry IF/ID buffer with valid/ready
// handshakes, flush, and combinational decode of the head entry.
// Ports:
//   clk    in  1  rising-edge clock
//   rstn   in  1  asynchronous active-low reset
//   flush  in  1  drop all buffered entries and any same-cycle input beat
//   bus    id_if.slave  fetch input handshake + decoded head outputs
// Optional feature: define ID_ILLEGAL_DET_EN to add bus.out_illegal.
// in_ready / out_valid are registered; no input reaches an output
// except through state.
// -----------------------------------------------------------------------------
module id_stage
    import id_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic flush,
    id_if.slave  bus
);

    cnt_e   r_state;
    cnt_e   w_state_nxt;
    entry_t r_head;
    entry_t r_tail;
    logic   r_in_ready;
    logic   r_out_valid;

    entry_t w_beat;
    logic   w_push;
    logic   w_pop;

    assign w_beat = {bus.in_pc, bus.in_instr};
    assign w_push = bus.in_valid & r_in_ready & ~flush;
    assign w_pop  = r_out_valid & bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = CNT_EMPTY;
        end else begin
            case (r_state)
                CNT_EMPTY: if (w_push) w_state_nxt = CNT_ONE;
                CNT_ONE: begin
                    if (w_push && !w_pop)      w_state_nxt = CNT_TWO;
                    else if (w_pop && !w_push) w_state_nxt = CNT_EMPTY;
                end
                CNT_TWO:   if (w_pop) w_state_nxt = CNT_ONE;
                default:   w_state_nxt = CNT_EMPTY;
            endcase
        end
    end

    // Handshake flags are derived from the next state so they are plain
    // flops at the outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= CNT_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            // NOTE: entries are reset too, so fields read as instr=0 / NONE
            // out of reset rather than X.
            r_head      <= '0;
            r_tail      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others.
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != CNT_TWO);
            r_out_valid <= (w_state_nxt != CNT_EMPTY);

            // Entry movement. w_push is already gated by flush; a pop during
            // flush may still promote the tail, which is harmless since the
            // state goes EMPTY.
            case (r_state)
                CNT_EMPTY: begin
                    if (w_push) r_head <= w_beat;
                end
                CNT_ONE: begin
                    if (w_push && w_pop) r_head <= w_beat;
                    else if (w_push)     r_tail <= w_beat;
                end
                CNT_TWO: begin
                    if (w_pop) r_head <= r_tail;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_pc    = r_head.pc;
    assign bus.out_instr = r_head.instr;

`ifdef ID_ILLEGAL_DET_EN
    logic w_illegal;
`endif

    id_decode u_decode (
        .instr      (r_head.instr),
        .rs1        (bus.out_rs1),
        .rs2        (bus.out_rs2),
        .rd         (bus.out_rd),
        .iimm_shamt (bus.out_iimm_shamt),
        .iimm       (bus.out_iimm),
        .simm       (bus.out_simm),
        .bimm       (bus.out_bimm),
        .uimm       (bus.out_uimm),
        .jimm       (bus.out_jimm),
        .ext_op     (bus.out_EXTOp)
`ifdef ID_ILLEGAL_DET_EN
        , .illegal  (w_illegal)
`endif
    );

`ifdef ID_ILLEGAL_DET_EN
    assign bus.out_illegal = r_out_valid & w_illegal;
`endif

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
// Directed testbench for id_stage. Inputs change 1 time unit after the rising
// edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_id_stage;

    logic clk;
    logic rstn;
    logic flush;

    int n_tests;
    int n_fail;

    id_if bus ();

    id_stage u_dut (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_instr = instr;
    endtask

    task automatic test_reset();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_tests++; if (bus.out_instr !== 32'h0 || bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_entry: got pc=%h instr=%h want 0/0", bus.out_pc, bus.out_instr); end
        n_tests++; if (bus.out_EXTOp !== 6'b111111) begin n_fail++; $display("FAIL reset_extop: got %b want 111111", bus.out_EXTOp); end
        n_tests++; if (bus.out_iimm !== 12'h0 || bus.out_rd !== 5'd0 || bus.out_jimm !== 20'h0) begin n_fail++; $display("FAIL reset_fields: got iimm=%h rd=%0d jimm=%h want 0", bus.out_iimm, bus.out_rd, bus.out_jimm); end
`ifdef ID_ILLEGAL_DET_EN
        n_tests++; if (bus.out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", bus.out_illegal); end
`endif
    endtask

    task automatic test_addi();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_0100, 32'hFFF0_0093);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", bus.out_valid); end
        n_tests++; if (bus.out_EXTOp !== 6'b000001) begin n_fail++; $display("FAIL addi_extop: got %b want 000001", bus.out_EXTOp); end
        n_tests++; if (bus.out_iimm !== 12'hFFF) begin n_fail++; $display("FAIL addi_iimm: got %h want fff", bus.out_iimm); end
        n_tests++; if (bus.out_rd !== 5'd1) begin n_fail++; $display("FAIL addi_rd: got %0d want 1", bus.out_rd); end
        n_tests++; if (bus.out_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL addi_pc: got %h want 00000100", bus.out_pc); end
        // Holding: no consumer, head stays put
        tick();
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF0_0093) begin n_fail++; $display("FAIL addi_hold: got v=%b instr=%h want 1/fff00093", bus.out_valid, bus.out_instr); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_pop: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0000_0200, 32'h0030_9093);
        tick();
        n_tests++; if (bus.out_EXTOp !== 6'b000000 || bus.out_iimm_shamt !== 5'd3) begin n_fail++; $display("FAIL b2b_slli: got extop=%b shamt=%0d want 000000/3", bus.out_EXTOp, bus.out_iimm_shamt); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); end
        drive(1'b1, 32'h0000_0204, 32'h0011_2623);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        n_tests++; if (bus.out_EXTOp !== 6'b000010 || bus.out_simm !== 12'h00C) begin n_fail++; $display("FAIL b2b_sw: got extop=%b simm=%h want 000010/00c", bus.out_EXTOp, bus.out_simm); end
        n_tests++; if (bus.out_rs1 !== 5'd2 || bus.out_rs2 !== 5'd1 || bus.out_pc !== 32'h0000_0204) begin n_fail++; $display("FAIL b2b_sw_regs: got rs1=%0d rs2=%0d pc=%h want 2/1/00000204", bus.out_rs1, bus.out_rs2, bus.out_pc); end
        tick();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_0300, 32'hFE00_0EE3);
        tick();
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: got %b want 1", bus.in_ready); end
        drive(1'b1, 32'h0000_0304, 32'h0080_006F);
        tick();
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_two: got %b want 0", bus.in_ready); end
        drive(1'b1, 32'h0000_0308, 32'h1234_52B7);
        tick();
        // Full and stalled: lui not taken, head still beq
        n_tests++; if (bus.in_ready !== 1'b0 || bus.out_pc !== 32'h0000_0300) begin n_fail++; $display("FAIL bp_stall: got ready=%b pc=%h want 0/00000300", bus.in_ready, bus.out_pc); end
        n_tests++; if (bus.out_bimm !== 12'hFFE || bus.out_EXTOp !== 6'b000011) begin n_fail++; $display("FAIL bp_beq: got bimm=%h extop=%b want ffe/000011", bus.out_bimm, bus.out_EXTOp); end
        bus.out_ready = 1'b1;
        tick();
        n_tests++; if (bus.out_jimm !== 20'h00004 || bus.out_EXTOp !== 6'b000101 || bus.out_pc !== 32'h0000_0304) begin n_fail++; $display("FAIL bp_jal: got jimm=%h extop=%b pc=%h want 00004/000101/00000304", bus.out_jimm, bus.out_EXTOp, bus.out_pc); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", bus.in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0);
        n_tests++; if (bus.out_uimm !== 20'h12345 || bus.out_EXTOp !== 6'b000100 || bus.out_pc !== 32'h0000_0308) begin n_fail++; $display("FAIL bp_lui: got uimm=%h extop=%b pc=%h want 12345/000100/00000308", bus.out_uimm, bus.out_EXTOp, bus.out_pc); end
        tick();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_0400, 32'h0000_0013);
        tick();
        drive(1'b1, 32'h0000_0404, 32'h0000_0017);
        tick();
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full: got ready=%b want 0", bus.in_ready); end
        flush = 1'b1;
        drive(1'b1, 32'h0000_0408, 32'h0000_006F);
        tick();
        n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_two: got v=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
        // Flush at ONE with an acceptable input beat: the beat is dropped
        flush = 1'b0;
        drive(1'b1, 32'h0000_0500, 32'h0000_0013);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h0000_0504, 32'h0000_0063);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_one: got v=%b want 0", bus.out_valid); end
        tick();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got v=%b want 0", bus.out_valid); end
        // Fresh beat after flush becomes the head
        drive(1'b1, 32'h0000_0600, 32'h0000_2003);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        n_tests++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0000_0600) begin n_fail++; $display("FAIL flush_fresh: got v=%b pc=%h want 1/00000600", bus.out_valid, bus.out_pc); end
        bus.out_ready = 1'b1;
        tick();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after: got v=%b want 0", bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_extop_table();
        logic [31:0] vi [11];
        logic [5:0]  ve [11];
        logic        vl [11];
        vi = '{32'h0000_5013, 32'h4000_5013, 32'h0000_2003, 32'h0000_0067, 32'h0000_0017,
               32'h0000_0033, 32'h0000_000F, 32'h0000_0073, 32'h0000_007F, 32'h0000_0013,
               32'h0000_0010};
        ve = '{6'b000000, 6'b000000, 6'b000001, 6'b000001, 6'b000100,
               6'b111111, 6'b111111, 6'b111111, 6'b111111, 6'b000001,
               6'b111111};
        vl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 32'h0000_0700 + 32'(i * 4), vi[i]);
            tick();
            n_tests++; if (bus.out_valid !== 1'b1 || bus.out_EXTOp !== ve[i]) begin n_fail++; $display("FAIL extop_%0d: instr=%h got v=%b extop=%b want 1/%b", i, vi[i], bus.out_valid, bus.out_EXTOp, ve[i]); end
`ifdef ID_ILLEGAL_DET_EN
            n_tests++; if (bus.out_illegal !== vl[i]) begin n_fail++; $display("FAIL illegal_%0d: instr=%h got %b want %b", i, vi[i], bus.out_illegal, vl[i]); end
`else
            if (vl[i] === 1'bx) $display("[TB] unexpected X in table");
`endif
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        bus.out_ready = 1'b0;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL extop_drain: got v=%b want 0", bus.out_valid); end
`ifdef ID_ILLEGAL_DET_EN
        n_tests++; if (bus.out_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_idle: got %b want 0", bus.out_illegal); end
`endif
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_0800, 32'hFFF0_0093);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got v=%b want 1", bus.out_valid); end
        #2;
        rstn = 1'b0;
        #1;
        n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_immediate: got v=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
        n_tests++; if (bus.out_instr !== 32'h0 || bus.out_EXTOp !== 6'b111111) begin n_fail++; $display("FAIL arst_entry: got instr=%h extop=%b want 0/111111", bus.out_instr, bus.out_EXTOp); end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after: got v=%b want 0", bus.out_valid); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        flush   = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rstn = 1'b1;
        tick();
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_extop_table();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
